// File: rtl/instr_fetch.sv
// instr_fetch: three-state instruction fetch with IR capture and field decode.
// Optional REQ-state abort counter enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        fetch_start,
    input  logic        mem_ready,
    input  logic [31:0] mem_data,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        busy,
    output logic        ir_valid,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic        addr_fault,
    output logic        timeout
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t state;
`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mem_addr   <= '0;
            instr      <= '0;
            mem_read   <= 1'b0;
            busy       <= 1'b0;
            ir_valid   <= 1'b0;
            addr_fault <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            timeout    <= 1'b0;
            cnt        <= '0;
`endif
        end else begin
            ir_valid   <= 1'b0;
            addr_fault <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            timeout    <= 1'b0;
`endif
            case (state)
                IDLE: if (fetch_start) begin
                    if (pc[1:0] == 2'b00) begin
                        state    <= REQ;
                        mem_addr <= pc;
                        mem_read <= 1'b1;
                        busy     <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                        cnt      <= '0;
`endif
                    end else begin
                        addr_fault <= 1'b1;
                    end
                end
                REQ: if (mem_ready) begin
                    state    <= DONE;
                    instr    <= mem_data;
                    mem_read <= 1'b0;
                    ir_valid <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    // Limit reached without data: abort, IR keeps its old value
                    state    <= IDLE;
                    mem_read <= 1'b0;
                    busy     <= 1'b0;
                    timeout  <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
`endif
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
`ifndef FETCH_TIMEOUT_EN
    assign timeout = 1'b0;
`endif
    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm16  = instr[15:0];
endmodule
